prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Byte-stream writer for the 32x8 program/data memory of the tiny accumulator core. The core is the reader of this memory.
- Parses load frames arriving on the dedicated input bus and writes them into the memory array.
- Exposes a combinational read port to the core.
- Holds the core in halt (cpu_hold) until a frame has loaded successfully, and during every load.

Parameters:
- DEPTH, 32, number of memory bytes; must be a power of 2.
- AW, 5, address width, equal to log2(DEPTH).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset. Name kept per codebase convention despite the suffix.
- in_data  input  8  incoming frame byte.
- in_valid  input  1  in_data is valid this cycle; one byte accepted per valid cycle; no backpressure.
- rd_addr  input  AW  core read address.
- rd_data  output  8  mem[rd_addr], combinational.
- cpu_hold  output  1  core must stall its PC while this is high.
- load_done  output  1  one-cycle pulse when a frame completes without error.
- err_code  output  2  sticky error: 00 none, 01 bad length, 10 checksum mismatch.
- busy  output  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE, busy=0, load_done=0, err_code=00.
  - load_ok=0, so cpu_hold=1.
  - Memory contents are not reset.
- Frame format: SYNC_BYTE, ADDR, LEN, LEN data bytes, CSUM.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM. Transitions occur only on cycles with in_valid=1.
  - IDLE: byte==SYNC_BYTE -> ADDR; also clear err_code, clear load_ok, csum=0. Any other byte is discarded and the FSM stays in IDLE.
  - ADDR: ptr<=byte[AW-1:0] (upper bits ignored); csum^=byte -> LEN.
  - LEN:
    - LEN==0 or LEN>DEPTH -> IDLE with err_code=01.
    - Otherwise cnt<=LEN, csum^=byte -> DATA.
  - DATA: mem[ptr]<=byte, ptr<=ptr+1 mod DEPTH (wraps 31->0), csum^=byte, cnt<=cnt-1. When the last byte is taken (cnt==1) -> CSUM.
  - CSUM:
    - byte==csum -> IDLE, load_ok<=1, load_done pulses the following cycle.
    - Mismatch -> IDLE, err_code=10, load_ok stays 0.
    - Data already written is not rolled back.
- Output relations:
  - cpu_hold = busy | ~load_ok, registered-state derived with no combinational path from in_data.
  - busy = (state!=IDLE).
- A SYNC_BYTE value arriving inside a frame is treated as data or length; there is no resync mid-frame.
- Cycles with in_valid=0 leave all state unchanged. There is no timeout.
- Read/write collision (same address, same cycle): rd_data returns the old contents; the new value is visible the next cycle.
- Reset mid-frame: immediate return to IDLE with cpu_hold=1. Partially written bytes remain in memory.
- load_done and err_code never assert in the same cycle.

Optional Feature:
- Macro: PROG_MEM_LOADER_CHECKSUM_EN.
- Defined: the CSUM state and checksum check behave as above.
- Undefined:
  - No CSUM byte is expected; the FSM goes DATA -> IDLE after the last data byte, with load_ok<=1 and a load_done pulse.
  - err_code value 10 is unreachable.
  - The csum register is removed.

Test Plan:
- Reset release then idle -> cpu_hold=1, busy=0, err_code=00, load_done=0.
- Frame A5,03,02,11,22,CSUM=03^02^11^22=0x32 (checksum enabled) -> mem[3]=0x11, mem[4]=0x22; load_done pulses once; cpu_hold falls to 0; rd_addr=4 gives 0x22.
- Wrap: frame A5,1F,02,AA,BB,correct CSUM -> mem[31]=0xAA, mem[0]=0xBB; mem[1] unchanged.
- Bad checksum: A5,00,01,55,00 -> mem[0]=0x55; err_code=10; cpu_hold=1; no load_done. Next A5 clears err_code.
- Bad length: A5,00,00 and A5,00,21 -> err_code=01 after the LEN byte; FSM back in IDLE; memory untouched.
- Assert rst_n during the DATA state with in_valid gaps -> immediate IDLE, cpu_hold=1; a fresh full frame then loads correctly. Bytes other than A5 in IDLE are ignored.

Source files
------------

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_loader
// Purpose  : Parses load frames from a byte stream and writes them into the
//            32x8 program/data memory of the accumulator core. The core reads
//            the memory through a combinational read port. The core is held
//            until a frame has loaded successfully, and during every load.
//
//            Frame layout: SYNC_BYTE, ADDR, LEN, LEN data bytes [, CSUM]
//            CSUM is the XOR of ADDR, LEN and all data bytes.
//
// Build option:
//   PROG_MEM_LOADER_CHECKSUM_EN  defined   -> a trailing CSUM byte is expected
//                                            and checked.
//                                undefined -> no CSUM byte. A frame completes
//                                            on its last data byte.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active HIGH (legacy name)
//   in_data    in   [7:0]     frame byte
//   in_valid   in   in_data valid this cycle (no backpressure)
//   rd_addr    in   [AW-1:0]  core read address
//   rd_data    out  [7:0]     mem[rd_addr], combinational
//   cpu_hold   out  core must stall while high
//   load_done  out  one-cycle pulse after a successful frame
//   err_code   out  [1:0]     sticky: 00 none, 01 bad length, 10 bad checksum
//   busy       out  FSM not in IDLE
//
// Revision : 1.0  initial release
// ============================================================================
module prog_mem_loader #(
    parameter int          DEPTH     = 32,
    parameter int          AW        = 5,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          cpu_hold,
    output logic          load_done,
    output logic [1:0]    err_code,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4
    } state_t;

    localparam logic [1:0] C_ERR_NONE = 2'b00;
    localparam logic [1:0] C_ERR_LEN  = 2'b01;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    localparam logic [1:0] C_ERR_CSUM = 2'b10;
`endif
    // LEN is compared on 9 bits so that LEN==DEPTH is representable.
    localparam logic [8:0] C_DEPTH9   = 9'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;          // holds 1..DEPTH
    logic          load_ok_q, load_ok_d;
    logic [1:0]    err_q, err_d;
    logic          load_done_q, load_done_d;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic [7:0]    mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Next-state and write-port logic. Nothing moves without in_valid.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        load_ok_d   = load_ok_q;
        err_d       = err_q;
        load_done_d = 1'b0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        wr_en       = 1'b0;
        wr_addr     = ptr_q;
        wr_data     = in_data;

        if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d   = S_ADDR;
                        err_d     = C_ERR_NONE;
                        load_ok_d = 1'b0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                        csum_d    = 8'h00;
`endif
                    end
                end
                S_ADDR: begin
                    ptr_d   = in_data[AW-1:0];
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if ((in_data == 8'h00) || ({1'b0, in_data} > C_DEPTH9)) begin
                        state_d = S_IDLE;
                        err_d   = C_ERR_LEN;
                    end else begin
                        cnt_d   = in_data[AW:0];
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                        csum_d  = csum_q ^ in_data;
`endif
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    wr_en   = 1'b1;
                    // DEPTH is a power of two, so the AW-bit add wraps.
                    ptr_d   = ptr_q + AW'(1);
                    cnt_d   = cnt_q - (AW+1)'(1);
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
                    if (cnt_q == (AW+1)'(1)) begin
                        state_d = S_CSUM;
                    end
`else
                    if (cnt_q == (AW+1)'(1)) begin
                        state_d     = S_IDLE;
                        load_ok_d   = 1'b1;
                        load_done_d = 1'b1;
                    end
`endif
                end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    state_d = S_IDLE;
                    // Data already written stays in memory on a mismatch.
                    if (in_data == csum_q) begin
                        load_ok_d   = 1'b1;
                        load_done_d = 1'b1;
                    end else begin
                        err_d = C_ERR_CSUM;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            load_ok_q   <= 1'b0;
            err_q       <= C_ERR_NONE;
            load_done_q <= 1'b0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            load_ok_q   <= load_ok_d;
            err_q       <= err_d;
            load_done_q <= load_done_d;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Memory array: not reset. A read of the address being written this
    // cycle returns the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data   = mem_q[rd_addr];

    // All of these come from registered state only.
    assign busy      = (state_q != S_IDLE);
    assign cpu_hold  = busy | ~load_ok_q;
    assign load_done = load_done_q;
    assign err_code  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_loader
// Purpose  : Self-checking bench for prog_mem_loader. A table of per-cycle
//            vectors covers normal frames, address wrap, checksum and length
//            errors. Hand-written sequences cover LEN==DEPTH and a reset in
//            the middle of a frame. Frames carry a CSUM byte only when
//            PROG_MEM_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_hold;
    logic       load_done;
    logic [1:0] err_code;
    logic       busy;

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    localparam logic CS = 1'b1;
`else
    localparam logic CS = 1'b0;
`endif

    always #5 clk = ~clk;

    prog_mem_loader #(
        .DEPTH     (32),
        .AW        (5),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err_code  (err_code),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [4:0] ra;
        logic       busy;
        logic       hold;
        logic       done;
        logic [1:0] err;
        logic       chk_rd;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic b, input logic h,
                            input logic dn, input logic [1:0] e);
        chk({tag, "_busy"}, {7'b0, busy},      {7'b0, b});
        chk({tag, "_hold"}, {7'b0, cpu_hold},  {7'b0, h});
        chk({tag, "_done"}, {7'b0, load_done}, {7'b0, dn});
        chk({tag, "_err"},  {6'b0, err_code},  {6'b0, e});
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [4:0] ra,
                       input logic b, input logic h, input logic dn,
                       input logic [1:0] e, input logic c, input logic [7:0] r);
        vec_t t;
        t.v = v; t.d = d; t.ra = ra; t.busy = b; t.hold = h; t.done = dn;
        t.err = e; t.chk_rd = c; t.rd = r;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic [4:0] ra);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        rd_addr  = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cs;
        logic [1:0] e_cs;
        e_cs = CS ? 2'b10 : 2'b00;

        // ---------------- vector table ----------------
        // Preload mem[1]=77 so the wrap test can show it untouched.
        add(1, 8'hA5, 5'd1, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h01, 5'd1, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h01, 5'd1, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h77, 5'd1, CS, CS, ~CS, 2'd0, 1, 8'h77);
        if (CS) add(1, 8'h77, 5'd1, 0, 0, 1, 2'd0, 1, 8'h77);
        add(0, 8'hA5, 5'd1, 0, 0, 0, 2'd0, 1, 8'h77);      // invalid A5 ignored
        // Frame A5,03,02,11,22[,32] with an in_valid gap inside DATA
        add(1, 8'hA5, 5'd3, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h03, 5'd3, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h02, 5'd3, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h11, 5'd3, 1, 1, 0, 2'd0, 1, 8'h11);
        add(0, 8'h11, 5'd3, 1, 1, 0, 2'd0, 1, 8'h11);
        add(1, 8'h22, 5'd4, CS, CS, ~CS, 2'd0, 1, 8'h22);
        if (CS) add(1, 8'h32, 5'd4, 0, 0, 1, 2'd0, 1, 8'h22);
        add(0, 8'h00, 5'd4, 0, 0, 0, 2'd0, 1, 8'h22);
        // Wrap: A5,1F,02,AA,BB[,0C]
        add(1, 8'hA5, 5'd0, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h1F, 5'd0, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h02, 5'd0, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'hAA, 5'd31, 1, 1, 0, 2'd0, 1, 8'hAA);
        add(1, 8'hBB, 5'd0, CS, CS, ~CS, 2'd0, 1, 8'hBB);
        if (CS) add(1, 8'h0C, 5'd0, 0, 0, 1, 2'd0, 1, 8'hBB);
        add(0, 8'h00, 5'd1, 0, 0, 0, 2'd0, 1, 8'h77);
        add(0, 8'h00, 5'd3, 0, 0, 0, 2'd0, 1, 8'h11);
        // A5,00,01,55[,00]: checksum is 54, so 00 is a mismatch
        add(1, 8'hA5, 5'd0, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h00, 5'd0, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h01, 5'd0, 1, 1, 0, 2'd0, 0, 8'h00);
        add(1, 8'h55, 5'd0, CS, CS, ~CS, 2'd0, 1, 8'h55);
        if (CS) add(1, 8'h00, 5'd0, 0, 1, 0, 2'b10, 1, 8'h55);
        add(0, 8'h00, 5'd0, 0, CS, 0, e_cs, 1, 8'h55);
        // Next sync clears err; then LEN=0 is rejected
        add(1, 8'hA5, 5'd0, 1, 1, 0, 2'd0, 1, 8'h55);
        add(1, 8'h00, 5'd0, 1, 1, 0, 2'd0, 1, 8'h55);
        add(1, 8'h00, 5'd0, 0, 1, 0, 2'b01, 1, 8'h55);
        add(0, 8'h00, 5'd0, 0, 1, 0, 2'b01, 1, 8'h55);
        // LEN=0x21 > DEPTH is rejected
        add(1, 8'hA5, 5'd0, 1, 1, 0, 2'd0, 1, 8'h55);
        add(1, 8'h00, 5'd0, 1, 1, 0, 2'd0, 1, 8'h55);
        add(1, 8'h21, 5'd0, 0, 1, 0, 2'b01, 1, 8'h55);
        add(1, 8'h33, 5'd0, 0, 1, 0, 2'b01, 1, 8'h55);     // non-sync byte in IDLE

        // ---------------- reset ----------------
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_addr  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset_held", 0, 1, 0, 2'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("reset_rel", 0, 1, 0, 2'd0);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].ra);
            chk_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].hold,
                     vecs[i].done, vecs[i].err);
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].rd);
        end

        // ---------------- LEN == DEPTH is accepted ----------------
        step(1, 8'hA5, 5'd0);
        step(1, 8'h00, 5'd0);
        step(1, 8'h20, 5'd0);
        chk_outs("len32_hdr", 1, 1, 0, 2'd0);
        cs = 8'h20;
        for (int i = 0; i < 32; i++) begin
            step(1, 8'(8'h40 + i), 5'd0);
            cs = cs ^ 8'(8'h40 + i);
        end
        if (CS) step(1, cs, 5'd0);
        chk_outs("len32_end", 0, 0, 1, 2'd0);
        step(0, 8'h00, 5'd0);
        chk("len32_m0", rd_data, 8'h40);
        step(0, 8'h00, 5'd31);
        chk("len32_m31", rd_data, 8'h5F);

        // ---------------- reset in the middle of DATA ----------------
        step(1, 8'hA5, 5'd5);
        step(1, 8'h05, 5'd5);
        step(1, 8'h03, 5'd5);
        step(1, 8'hC1, 5'd5);
        step(0, 8'h00, 5'd5);
        chk_outs("mid_pre", 1, 1, 0, 2'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk_outs("mid_rst", 0, 1, 0, 2'd0);
        chk("mid_rst_m5", rd_data, 8'hC1);
        @(negedge clk);
        rst_n = 1'b0;
        step(1, 8'h12, 5'd5);
        step(1, 8'h34, 5'd5);
        chk_outs("idle_junk", 0, 1, 0, 2'd0);
        step(1, 8'hA5, 5'd5);
        step(1, 8'h05, 5'd5);
        step(1, 8'h03, 5'd5);
        step(1, 8'hD1, 5'd5);
        step(1, 8'hD2, 5'd5);
        step(1, 8'hD3, 5'd5);
        if (CS) step(1, 8'hD6, 5'd5);
        chk_outs("fresh_end", 0, 0, 1, 2'd0);
        step(0, 8'h00, 5'd5);
        chk("fresh_m5", rd_data, 8'hD1);
        chk_outs("fresh_after", 0, 0, 0, 2'd0);
        step(0, 8'h00, 5'd6);
        chk("fresh_m6", rd_data, 8'hD2);
        step(0, 8'h00, 5'd7);
        chk("fresh_m7", rd_data, 8'hD3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
